mem_arbiter: RTL and testbench

- Single-port memory arbiter upstream of the hazard unit.
- Merges the fetch-stage instruction read and the memory-stage data read/write onto one word-wide RAM port.
- Returns the per-request completion pulses ihit/dhit that the hazard unit uses to stall or bubble the pipeline.
- Data side has priority, with a one-shot fairness rule so fetch is never starved; a watchdog flags a RAM that never answers.

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/access_watchdog.sv | 39 +++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word type, arbiter state encoding and default
// RAM-access timeout.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2
  } arb_state_t;

  localparam int ARB_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/access_watchdog.sv
// Counts RAM wait cycles of the access in flight and pulses expire once the
// access has waited TIMEOUT_CYCLES cycles without ram_ready.
module access_watchdog
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic ready,
  output logic expire
);

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (!ready) begin
      if (cnt_q == LAST_CNT) begin
        expire = 1'b1;
        cnt_d  = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for instruction fetch and data access. Data wins
// arbitration except right after a data access when a fetch is waiting.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT,
  parameter int ADDR_W         = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [31:0]       iload,
  output logic              ihit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [31:0]       dstore,
  output logic [31:0]       dload,
  output logic              dhit,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_store,
  input  logic [31:0]       ram_load,
  input  logic              ram_ready,
  output logic              bus_err
);

  arb_state_t state_q, state_d;
  logic       last_was_d_q, last_was_d_d;
  logic       bus_err_q, bus_err_d;
  logic       wd_clear, wd_expire;
  logic       d_req;

  assign d_req    = dREN | dWEN;
  assign wd_clear = (state_q == IDLE);
  assign bus_err  = bus_err_q;

  access_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .CLK    (CLK),
    .nRST   (nRST),
    .clear  (wd_clear),
    .ready  (ram_ready),
    .expire (wd_expire)
  );

  always_comb begin
    state_d      = state_q;
    last_was_d_d = last_was_d_q;
    bus_err_d    = bus_err_q;
    ram_ren      = 1'b0;
    ram_wen      = 1'b0;
    ram_addr     = '0;
    ram_store    = '0;
    ihit         = 1'b0;
    dhit         = 1'b0;
    iload        = '0;
    dload        = '0;

    unique case (state_q)
      IDLE: begin
        // A waiting fetch gets the slot right after a data access.
        if (d_req && !(last_was_d_q && iREN)) state_d = D_ACC;
        else if (iREN)                        state_d = I_ACC;
      end

      D_ACC: begin
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ram_addr  = daddr;
          ram_ren   = dREN & ~dWEN;
          ram_wen   = dWEN;
          ram_store = dstore;
          if (dREN && dWEN) bus_err_d = 1'b1;
          if (ram_ready) begin
            dhit         = 1'b1;
            dload        = ram_load;
            last_was_d_d = 1'b1;
            state_d      = IDLE;
          end else if (wd_expire) begin
            bus_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      I_ACC: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ram_addr = iaddr;
          ram_ren  = 1'b1;
          if (ram_ready) begin
            ihit         = 1'b1;
            iload        = ram_load;
            last_was_d_d = 1'b0;
            state_d      = IDLE;
          end else if (wd_expire) begin
            bus_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      last_was_d_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_was_d_q <= last_was_d_d;
      bus_err_q    <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a short watchdog timeout.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        ihit;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dhit;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic [31:0] ram_load;
  logic        ram_ready;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  int nd, ni;
  logic [31:0] exp_addr;

  always #5 CLK = ~CLK;

  mem_arbiter #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iload     (iload),
    .ihit      (ihit),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .dload     (dload),
    .dhit      (dhit),
    .ram_ren   (ram_ren),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_store (ram_store),
    .ram_load  (ram_load),
    .ram_ready (ram_ready),
    .bus_err   (bus_err)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; iREN = 1'b1; iaddr = 32'h40; dREN = 1'b0; dWEN = 1'b1;
    daddr = 32'h100; dstore = 32'hFFFF_FFFF; ram_load = 32'hFFFF_FFFF; ram_ready = 1'b1;

    // reset state: all outputs low even with requests present
    #12;
    chk1("rst_ram_ren", ram_ren, 1'b0);
    chk1("rst_ram_wen", ram_wen, 1'b0);
    chk32("rst_ram_addr", ram_addr, 32'h0);
    chk32("rst_ram_store", ram_store, 32'h0);
    chk1("rst_ihit", ihit, 1'b0);
    chk1("rst_dhit", dhit, 1'b0);
    chk32("rst_iload", iload, 32'h0);
    chk32("rst_dload", dload, 32'h0);
    chk1("rst_bus_err", bus_err, 1'b0);
    iREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0; ram_load = 32'h0;
    cyc;
    nRST = 1'b1;

    // instruction read, RAM ready in the third access cycle
    cyc; iREN = 1'b1; iaddr = 32'h0000_0040;
    @(negedge CLK); chk1("i_c0_ren", ram_ren, 1'b0);
    cyc;
    @(negedge CLK);
    chk1("i_c1_ren", ram_ren, 1'b1);
    chk32("i_c1_addr", ram_addr, 32'h40);
    chk1("i_c1_ihit", ihit, 1'b0);
    cyc;
    @(negedge CLK);
    chk1("i_c2_ren", ram_ren, 1'b1);
    chk1("i_c2_ihit", ihit, 1'b0);
    cyc; ram_ready = 1'b1; ram_load = 32'h2408_0005;
    @(negedge CLK);
    chk1("i_c3_ihit", ihit, 1'b1);
    chk32("i_c3_iload", iload, 32'h2408_0005);
    chk1("i_c3_dhit", dhit, 1'b0);
    cyc; iREN = 1'b0; ram_ready = 1'b0;
    @(negedge CLK);
    chk1("i_c4_ihit", ihit, 1'b0);
    chk32("i_c4_iload", iload, 32'h0);

    // continuous contention: D,I,D,I... one hit every two cycles
    cyc; iREN = 1'b1; dREN = 1'b1; iaddr = 32'h200; daddr = 32'h300;
    ram_ready = 1'b1; ram_load = 32'hA5A5_0000;
    nd = 0; ni = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      chk1("cont_dhit", dhit, (c % 4) == 1);
      chk1("cont_ihit", ihit, (c % 4) == 3);
      exp_addr = ((c % 4) == 1) ? 32'h300 : (((c % 4) == 3) ? 32'h200 : 32'h0);
      chk32("cont_addr", ram_addr, exp_addr);
      if (dhit) nd++;
      if (ihit) ni++;
      cyc;
    end
    iREN = 1'b0; dREN = 1'b0;
    chk32("cont_n_dhit", nd, 32'd4);
    chk32("cont_n_ihit", ni, 32'd4);

    // data write, RAM ready immediately
    @(negedge CLK); chk1("w_idle_ren", ram_ren, 1'b0);
    cyc; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
    @(negedge CLK);
    chk1("w_c0_dhit", dhit, 1'b0);
    chk1("w_c0_wen", ram_wen, 1'b0);
    cyc;
    @(negedge CLK);
    chk1("w_c1_wen", ram_wen, 1'b1);
    chk1("w_c1_ren", ram_ren, 1'b0);
    chk32("w_c1_store", ram_store, 32'hDEAD_BEEF);
    chk32("w_c1_addr", ram_addr, 32'h100);
    chk1("w_c1_dhit", dhit, 1'b1);
    chk1("w_c1_ihit", ihit, 1'b0);
    cyc; dWEN = 1'b0; ram_ready = 1'b0;
    @(negedge CLK);
    chk1("w_c2_dhit", dhit, 1'b0);
    chk1("w_c2_wen", ram_wen, 1'b0);

    // data read withdrawn mid-access
    cyc; dREN = 1'b1; daddr = 32'h140;
    cyc;
    @(negedge CLK); chk1("wd_c1_ren", ram_ren, 1'b1);
    cyc; dREN = 1'b0;
    #1 chk1("wd_drop_ren", ram_ren, 1'b0);
    @(negedge CLK); chk1("wd_c2_dhit", dhit, 1'b0);
    cyc; iREN = 1'b1; iaddr = 32'h44; ram_ready = 1'b1; ram_load = 32'h1111_2222;
    @(negedge CLK);
    chk1("wd_c3_ihit", ihit, 1'b0);
    chk1("wd_c3_dhit", dhit, 1'b0);
    cyc;
    @(negedge CLK);
    chk1("wd_c4_ihit", ihit, 1'b1);
    chk32("wd_c4_iload", iload, 32'h1111_2222);
    cyc; iREN = 1'b0; ram_ready = 1'b0;

    // watchdog: RAM never ready, abort after 4 access cycles
    @(negedge CLK); chk1("to_pre_err", bus_err, 1'b0);
    cyc; iREN = 1'b1; iaddr = 32'h80;
    for (int k = 1; k <= 4; k++) begin
      cyc;
      @(negedge CLK);
      chk1("to_acc_ren", ram_ren, 1'b1);
      chk1("to_acc_ihit", ihit, 1'b0);
      chk1("to_acc_err", bus_err, 1'b0);
    end
    cyc;
    @(negedge CLK);
    chk1("to_abort_ren", ram_ren, 1'b0);
    chk1("to_abort_ihit", ihit, 1'b0);
    chk1("to_abort_err", bus_err, 1'b1);
    cyc; ram_ready = 1'b1; ram_load = 32'h3333_4444;
    @(negedge CLK);
    chk1("to_retry_ihit", ihit, 1'b1);
    chk32("to_retry_iload", iload, 32'h3333_4444);
    cyc; iREN = 1'b0; dREN = 1'b1; daddr = 32'h180; ram_load = 32'h5555_6666;
    @(negedge CLK);
    chk1("to_d_c0_dhit", dhit, 1'b0);
    chk1("to_d_c0_err", bus_err, 1'b1);
    cyc;
    @(negedge CLK);
    chk1("to_d_c1_dhit", dhit, 1'b1);
    chk32("to_d_c1_dload", dload, 32'h5555_6666);
    chk1("to_d_c1_err", bus_err, 1'b1);
    cyc; dREN = 1'b0; ram_ready = 1'b0;
    @(negedge CLK); chk1("to_sticky_err", bus_err, 1'b1);

    // reset pulsed mid data access
    cyc; dWEN = 1'b1; daddr = 32'h1C0; dstore = 32'h0BAD_F00D;
    cyc;
    @(negedge CLK); chk1("rs_c1_wen", ram_wen, 1'b1);
    #1 nRST = 1'b0;
    #1;
    chk1("rs_wen", ram_wen, 1'b0);
    chk32("rs_addr", ram_addr, 32'h0);
    chk32("rs_store", ram_store, 32'h0);
    chk1("rs_dhit", dhit, 1'b0);
    chk1("rs_err", bus_err, 1'b0);
    dWEN = 1'b0;
    cyc; nRST = 1'b1;
    iREN = 1'b1; iaddr = 32'h48; ram_ready = 1'b1; ram_load = 32'h7777_8888;
    @(negedge CLK);
    chk1("rs_c0_ihit", ihit, 1'b0);
    chk1("rs_c0_ren", ram_ren, 1'b0);
    cyc;
    @(negedge CLK);
    chk1("rs_c1_ihit", ihit, 1'b1);
    chk32("rs_c1_iload", iload, 32'h7777_8888);
    chk32("rs_c1_addr", ram_addr, 32'h48);
    cyc; iREN = 1'b0; ram_ready = 1'b0;

    // read and write together: treated as write, flags bus_err
    cyc; dREN = 1'b1; dWEN = 1'b1; daddr = 32'h1E0; dstore = 32'h1234_5678;
    cyc;
    @(negedge CLK);
    chk1("rw_c1_wen", ram_wen, 1'b1);
    chk1("rw_c1_ren", ram_ren, 1'b0);
    chk1("rw_c1_err", bus_err, 1'b0);
    cyc; ram_ready = 1'b1;
    @(negedge CLK);
    chk1("rw_c2_err", bus_err, 1'b1);
    chk1("rw_c2_dhit", dhit, 1'b1);
    cyc; dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
    @(negedge CLK);
    chk1("rw_c3_dhit", dhit, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
